phase_frame_rx: RTL

PHASE_FRAME_RX -- requirements
Module: phase_frame_rx

---
 rtl/phase_frame_rx_if.sv | 23 ++
 rtl/phase_frame_rx.sv | 118 +++++++++++
 2 files changed

// File: rtl/phase_frame_rx_if.sv
// Byte-stream receive, bank-read and status signals of the phase frame receiver.
// master drives the UART byte stream, the carrier tick and the read address.
interface phase_frame_rx_if;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       sync_tick;
  logic [5:0] rd_addr;
  logic [7:0] rd_phase;
  logic       frame_ok;
  logic       frame_err;
  logic       busy;
  logic       bank_sel;

  modport master (
    output rx_byte, rx_valid, sync_tick, rd_addr,
    input  rd_phase, frame_ok, frame_err, busy, bank_sel
  );

  modport slave (
    input  rx_byte, rx_valid, sync_tick, rd_addr,
    output rd_phase, frame_ok, frame_err, busy, bank_sel
  );
endinterface

// File: rtl/phase_frame_rx.sv
// Receives header/payload/checksum phase frames into a shadow bank and swaps
// it with the active bank on the carrier-period boundary after a good checksum.
module phase_frame_rx #(
  parameter logic [7:0] HEADER  = 8'hAA,
  parameter int         NCH     = 64,
  parameter int         TIMEOUT = 50000
) (
  input  logic           clk,
  input  logic           rst,
  phase_frame_rx_if.slave bus
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK, PEND} state_t;

  state_t         r_state, w_next;
  logic [CW-1:0]  r_cnt;
  logic [7:0]     r_cks;
  logic [TW-1:0]  r_timer;
  logic [7:0]     r_bank0 [NCH];
  logic [7:0]     r_bank1 [NCH];
  logic           r_bank_sel;
  logic [7:0]     r_rd_phase;
  logic           r_frame_ok;
  logic           r_frame_err;

  logic           w_hdr, w_wr, w_last, w_match, w_bad, w_tmo, w_swap, w_inframe;
  logic [CW-1:0]  w_rd_idx;

  assign w_rd_idx  = CW'(bus.rd_addr);
  assign w_inframe = (r_state == PAYLOAD) || (r_state == CHECK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_hdr   = 1'b0;
    w_wr    = 1'b0;
    w_last  = 1'b0;
    w_match = 1'b0;
    w_bad   = 1'b0;
    w_tmo   = 1'b0;
    w_swap  = 1'b0;
    // Silence counts only while a frame is being collected, not while pending.
    if (w_inframe && !bus.rx_valid && (r_timer == TW'(TIMEOUT - 1)))
      w_tmo = 1'b1;
    unique case (r_state)
      IDLE: if (bus.rx_valid && bus.rx_byte == HEADER) begin
        w_hdr  = 1'b1;
        w_next = PAYLOAD;
      end
      PAYLOAD: begin
        w_wr   = bus.rx_valid;
        w_last = bus.rx_valid && (r_cnt == CW'(NCH - 1));
        if (w_tmo)       w_next = IDLE;
        else if (w_last) w_next = CHECK;
      end
      CHECK: begin
        w_match = bus.rx_valid && (bus.rx_byte == r_cks);
        w_bad   = bus.rx_valid && (bus.rx_byte != r_cks);
        w_swap  = w_match && bus.sync_tick;
        if (w_tmo || w_bad) w_next = IDLE;
        else if (w_match)   w_next = w_swap ? IDLE : PEND;
      end
      PEND: begin
        w_swap = bus.sync_tick;
        if (w_swap) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_cks       <= '0;
      r_timer     <= '0;
      r_bank_sel  <= 1'b0;
      r_rd_phase  <= '0;
      r_frame_ok  <= 1'b0;
      r_frame_err <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        r_bank0[i] <= '0;
        r_bank1[i] <= '0;
      end
    end else begin
      r_frame_ok  <= w_swap;
      r_frame_err <= w_bad || w_tmo;
      // Read uses the pre-toggle select, so a swap shows on the next read.
      r_rd_phase  <= r_bank_sel ? r_bank1[w_rd_idx] : r_bank0[w_rd_idx];
      if (w_swap) r_bank_sel <= ~r_bank_sel;

      if (w_hdr || (w_inframe && bus.rx_valid)) r_timer <= '0;
      else if (w_inframe)                       r_timer <= r_timer + 1'b1;
      else                                      r_timer <= '0;

      if (w_hdr) begin
        r_cnt <= '0;
        r_cks <= '0;
      end else if (w_wr) begin
        r_cnt <= r_cnt + 1'b1;
        r_cks <= r_cks + bus.rx_byte;
        if (r_bank_sel) r_bank0[r_cnt] <= bus.rx_byte;
        else            r_bank1[r_cnt] <= bus.rx_byte;
      end
    end
  end

  assign bus.rd_phase  = r_rd_phase;
  assign bus.frame_ok  = r_frame_ok;
  assign bus.frame_err = r_frame_err;
  assign bus.busy      = (r_state != IDLE);
  assign bus.bank_sel  = r_bank_sel;
endmodule
